pipeline_stage_reg: RTL and testbench
=====================================

PIPELINE_STAGE_REG -- requirements
Module: pipeline_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 96, the operand payload width (DataA/DataB/imm).
REQ-002 SHALL have parameter CTRL_W, default 9, the control-bundle width (WB 2 + M 3 + EX 4).
REQ-003 SHALL have parameter TAG_W, default 15, the register-index payload width (Rs/Rt/Rd, 3x5).
REQ-004 Ports:
- clock  in  1  sole clock; all state on its rising edge.
- reset  in  1  asynchronous, active-high.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat.
- in_ctrl  in  CTRL_W  control bundle.
- in_data  in  DATA_W  operand payload.
- in_tag  in  TAG_W  register indices.
- out_valid  out  1  downstream beat present.
- out_ready  in  1  downstream accepts the beat.
- out_ctrl  out  CTRL_W  control; zero whenever out_valid=0.
- out_data  out  DATA_W  operand payload.
- out_tag  out  TAG_W  register indices.
- occupancy  out  2  held entries, 0..2.

Function
REQ-005 Stage SHALL be a 2-entry skid buffer: a main register (drives outputs) and a skid register.
REQ-006 State machine SHALL have states EMPTY (0 entries), ONE (main valid), TWO (main and skid valid); occupancy SHALL equal 0/1/2 respectively.
REQ-007 in_ready SHALL be a registered signal, equal to 1 in EMPTY and ONE and 0 in TWO; no combinational path from out_ready to in_ready.
REQ-008 Accept SHALL occur when in_valid && in_ready; dequeue SHALL occur when out_valid && out_ready.
REQ-009 EMPTY: accept -> ONE, beat written to main.
REQ-010 ONE: accept without dequeue -> TWO, beat written to skid; dequeue without accept -> EMPTY; accept with dequeue -> ONE, beat written to main.
REQ-011 TWO: dequeue -> ONE, skid moves to main; no accept is possible.
REQ-012 Beats SHALL leave in arrival order; none dropped or duplicated except by flush.
REQ-013 Latency SHALL be 1 cycle: a beat accepted at edge N into EMPTY is presented on out_* after edge N.
REQ-014 Throughput SHALL be one beat per cycle while out_ready=1.
REQ-015 out_ctrl SHALL be masked to 0 whenever out_valid=0 (bubble is a NOP); out_data/out_tag are don't-care then.
REQ-016 flush SHALL move state to EMPTY at the next edge, overriding any simultaneous accept or dequeue; a beat accepted in the flush cycle SHALL be discarded.
REQ-017 flush SHALL not clear data/tag registers; only valid state is cleared.
REQ-018 Payload registers SHALL load only on accept or skid-to-main move; held otherwise (stall holds contents).

Reset
REQ-019 reset SHALL force EMPTY immediately, without waiting for a clock edge: out_valid=0, out_ctrl=0, occupancy=0, in_ready=1.
REQ-020 out_data and out_tag SHALL reset to 0.
REQ-021 Reset asserted mid-transfer SHALL discard all held beats; the first accept after deassertion behaves as from EMPTY.

Structure
REQ-022 Shared package SHALL hold the state encoding (EMPTY/ONE/TWO) and the default widths: CTRL_W=9, DATA_W=96, TAG_W=15.
REQ-023 One sub-module, stage_entry_reg, SHALL implement a single {valid, ctrl, data, tag} register with a load enable, instanced twice (main, skid).

Verification
REQ-024 Reset: after reset, out_valid=0, out_ctrl=0, in_ready=1, occupancy=0.
REQ-025 Streaming: out_ready=1, beats data=1,2,3 on consecutive cycles -> out_data 1,2,3 on the following consecutive cycles, occupancy stays 1.
REQ-026 Backpressure: out_ready=0, send beats A=0x11 and B=0x22 -> occupancy=2 and in_ready=0; raise out_ready -> A then B, in_ready returns 1 one cycle after the first dequeue.
REQ-027 Flush priority: in TWO, assert flush with in_valid=1, out_ready=1 -> next cycle occupancy=0, out_valid=0, out_ctrl=0; no beat emitted afterward.
REQ-028 Mask: with the stage empty and in_ctrl=9'h1FF driven while in_valid=0 -> out_ctrl stays 0.
REQ-029 Async reset: assert reset mid-cycle in ONE -> out_valid=0 before the next clock edge.

Source files
------------

// File: rtl/pipeline_stage_reg_pkg.sv
// Shared state encoding and default payload widths for the pipeline stage register.
package pipeline_stage_reg_pkg;

   localparam int unsigned DEF_CTRL_W = 9;   // WB 2 + M 3 + EX 4
   localparam int unsigned DEF_DATA_W = 96;  // DataA / DataB / imm
   localparam int unsigned DEF_TAG_W  = 15;  // Rs / Rt / Rd

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } stage_state_t;

endpackage

// File: rtl/pipeline_stage_reg_entry.sv
// One {valid, ctrl, data, tag} holding register; ctrl is cleared whenever the entry goes invalid.
module stage_entry_reg #(
   parameter int unsigned CTRL_W = 9,
   parameter int unsigned DATA_W = 96,
   parameter int unsigned TAG_W  = 15
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load,
   input  logic              valid_d,
   input  logic [CTRL_W-1:0] d_ctrl,
   input  logic [DATA_W-1:0] d_data,
   input  logic [TAG_W-1:0]  d_tag,
   output logic              q_valid,
   output logic [CTRL_W-1:0] q_ctrl,
   output logic [DATA_W-1:0] q_data,
   output logic [TAG_W-1:0]  q_tag
);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         q_valid <= 1'b0;
         q_ctrl  <= '0;
         q_data  <= '0;
         q_tag   <= '0;
      end else begin
         q_valid <= valid_d;
         // Bubble carries a NOP control word so downstream never sees stale control.
         if (!valid_d)
            q_ctrl <= '0;
         else if (load)
            q_ctrl <= d_ctrl;
         if (load) begin
            q_data <= d_data;
            q_tag  <= d_tag;
         end
      end
   end

endmodule

// File: rtl/pipeline_stage_reg.sv
// Two-entry skid-buffer pipeline stage with registered in_ready, flush and masked bubble control.
module pipeline_stage_reg
   import pipeline_stage_reg_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned CTRL_W = DEF_CTRL_W,
   parameter int unsigned TAG_W  = DEF_TAG_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [TAG_W-1:0]  out_tag,
   output logic [1:0]        occupancy
);

   stage_state_t state, state_next;
   logic         in_ready_q;
   logic         accept, dequeue;
   logic         main_load, skid_load, main_valid_d, skid_valid_d;

   logic              main_valid, skid_valid;
   logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;
   logic [DATA_W-1:0] main_data, skid_data, main_d_data;
   logic [TAG_W-1:0]  main_tag, skid_tag, main_d_tag;

   assign accept  = in_valid && in_ready_q;
   assign dequeue = main_valid && out_ready;

   // State and registered ready; ready is decoded from next state so it never sees out_ready combinationally.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= ST_EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state      <= state_next;
         in_ready_q <= (state_next != ST_TWO);
      end
   end

   always_comb begin
      state_next = state;
      main_load  = 1'b0;
      skid_load  = 1'b0;
      unique case (state)
         ST_EMPTY: begin
            if (accept) begin
               state_next = ST_ONE;
               main_load  = 1'b1;
            end
         end
         ST_ONE: begin
            if (accept && !dequeue) begin
               state_next = ST_TWO;
               skid_load  = 1'b1;
            end else if (!accept && dequeue) begin
               state_next = ST_EMPTY;
            end else if (accept && dequeue) begin
               main_load  = 1'b1;
            end
         end
         ST_TWO: begin
            if (dequeue) begin
               state_next = ST_ONE;
               main_load  = 1'b1;
            end
         end
         default: state_next = ST_EMPTY;
      endcase
      if (flush) begin
         state_next = ST_EMPTY;
         main_load  = 1'b0;
         skid_load  = 1'b0;
      end
      main_valid_d = (state_next != ST_EMPTY);
      skid_valid_d = (state_next == ST_TWO);
   end

   // Main only reloads from skid while skid holds the older beat (TWO); otherwise from the input.
   always_comb begin
      main_d_ctrl = skid_valid ? skid_ctrl : in_ctrl;
      main_d_data = skid_valid ? skid_data : in_data;
      main_d_tag  = skid_valid ? skid_tag  : in_tag;
   end

   stage_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) u_main (
      .clock   (clock),
      .reset   (reset),
      .load    (main_load),
      .valid_d (main_valid_d),
      .d_ctrl  (main_d_ctrl),
      .d_data  (main_d_data),
      .d_tag   (main_d_tag),
      .q_valid (main_valid),
      .q_ctrl  (main_ctrl),
      .q_data  (main_data),
      .q_tag   (main_tag)
   );

   stage_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) u_skid (
      .clock   (clock),
      .reset   (reset),
      .load    (skid_load),
      .valid_d (skid_valid_d),
      .d_ctrl  (in_ctrl),
      .d_data  (in_data),
      .d_tag   (in_tag),
      .q_valid (skid_valid),
      .q_ctrl  (skid_ctrl),
      .q_data  (skid_data),
      .q_tag   (skid_tag)
   );

   assign in_ready  = in_ready_q;
   assign out_valid = main_valid;
   assign out_ctrl  = main_ctrl;
   assign out_data  = main_data;
   assign out_tag   = main_tag;
   assign occupancy = 2'(state);

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Directed self-checking bench for pipeline_stage_reg: reset, streaming, backpressure, flush, mask, async reset.
module tb_pipeline_stage_reg;

   localparam int unsigned DATA_W = 96;
   localparam int unsigned CTRL_W = 9;
   localparam int unsigned TAG_W  = 15;

   logic              clock = 1'b0;
   logic              reset, flush, in_valid, in_ready, out_valid, out_ready;
   logic [CTRL_W-1:0] in_ctrl, out_ctrl;
   logic [DATA_W-1:0] in_data, out_data;
   logic [TAG_W-1:0]  in_tag, out_tag;
   logic [1:0]        occupancy;

   int n_cmp = 0;
   int n_err = 0;

   pipeline_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .TAG_W(TAG_W)) dut (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl),
      .out_data  (out_data),
      .out_tag   (out_tag),
      .occupancy (occupancy)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One rising edge, then settle on the falling edge where checks and new inputs happen.
   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                        input logic [TAG_W-1:0] t);
      in_valid = v;
      in_ctrl  = c;
      in_data  = d;
      in_tag   = t;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, '0, '0, '0);
      repeat (2) @(negedge clock);
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_out_ctrl",  128'(out_ctrl),  128'(0));
      check("rst_in_ready",  128'(in_ready),  128'(1));
      check("rst_occupancy", 128'(occupancy), 128'(0));
      check("rst_out_data",  128'(out_data),  128'(0));
      check("rst_out_tag",   128'(out_tag),   128'(0));
      reset = 1'b0;

      // Bubble control mask
      drive(1'b0, 9'h1FF, 96'hABC, 15'h7FF);
      step();
      check("mask_out_ctrl",  128'(out_ctrl),  128'(0));
      check("mask_out_valid", 128'(out_valid), 128'(0));

      // Streaming with out_ready high
      out_ready = 1'b1;
      drive(1'b1, 9'h005, 96'd1, 15'h0007);
      step();
      check("strm1_valid", 128'(out_valid), 128'(1));
      check("strm1_data",  128'(out_data),  128'(1));
      check("strm1_ctrl",  128'(out_ctrl),  128'(9'h005));
      check("strm1_tag",   128'(out_tag),   128'(15'h0007));
      check("strm1_occ",   128'(occupancy), 128'(1));
      drive(1'b1, 9'h006, 96'd2, 15'h0008);
      step();
      check("strm2_data", 128'(out_data),  128'(2));
      check("strm2_occ",  128'(occupancy), 128'(1));
      drive(1'b1, 9'h007, 96'd3, 15'h0009);
      step();
      check("strm3_data", 128'(out_data),  128'(3));
      check("strm3_occ",  128'(occupancy), 128'(1));
      drive(1'b0, 9'h1FF, 96'd0, 15'h0);
      step();
      check("strm_drain_valid", 128'(out_valid), 128'(0));
      check("strm_drain_ctrl",  128'(out_ctrl),  128'(0));
      check("strm_drain_occ",   128'(occupancy), 128'(0));

      // Backpressure fills the skid entry
      out_ready = 1'b0;
      drive(1'b1, 9'h011, 96'h11, 15'h0011);
      step();
      check("bp_a_occ",   128'(occupancy), 128'(1));
      check("bp_a_ready", 128'(in_ready),  128'(1));
      drive(1'b1, 9'h022, 96'h22, 15'h0022);
      step();
      check("bp_full_occ",   128'(occupancy), 128'(2));
      check("bp_full_ready", 128'(in_ready),  128'(0));
      check("bp_full_data",  128'(out_data),  128'(96'h11));
      drive(1'b1, 9'h033, 96'h33, 15'h0033);  // must be refused while full
      step();
      check("bp_stall_data", 128'(out_data),  128'(96'h11));
      check("bp_stall_ctrl", 128'(out_ctrl),  128'(9'h011));
      check("bp_stall_occ",  128'(occupancy), 128'(2));
      drive(1'b0, '0, '0, '0);
      out_ready = 1'b1;
      step();
      check("bp_b_data",  128'(out_data),  128'(96'h22));
      check("bp_b_tag",   128'(out_tag),   128'(15'h0022));
      check("bp_b_occ",   128'(occupancy), 128'(1));
      check("bp_b_ready", 128'(in_ready),  128'(1));
      step();
      check("bp_end_valid", 128'(out_valid), 128'(0));

      // Flush in TWO beats a simultaneous accept and dequeue
      out_ready = 1'b0;
      drive(1'b1, 9'h044, 96'h44, 15'h0044);
      step();
      drive(1'b1, 9'h055, 96'h55, 15'h0055);
      step();
      check("fl_pre_occ", 128'(occupancy), 128'(2));
      drive(1'b1, 9'h066, 96'h66, 15'h0066);
      flush = 1'b1; out_ready = 1'b1;
      step();
      check("fl_occ",   128'(occupancy), 128'(0));
      check("fl_valid", 128'(out_valid), 128'(0));
      check("fl_ctrl",  128'(out_ctrl),  128'(0));
      check("fl_ready", 128'(in_ready),  128'(1));
      check("fl_data_held", 128'(out_data), 128'(96'h44));
      flush = 1'b0;
      drive(1'b0, '0, '0, '0);
      step();
      check("fl_after_valid", 128'(out_valid), 128'(0));
      check("fl_after_occ",   128'(occupancy), 128'(0));

      // Asynchronous reset in ONE, between edges
      out_ready = 1'b0;
      drive(1'b1, 9'h077, 96'h77, 15'h0077);
      step();
      check("ar_pre_valid", 128'(out_valid), 128'(1));
      drive(1'b0, '0, '0, '0);
      #1 reset = 1'b1;
      #1;
      check("ar_valid", 128'(out_valid), 128'(0));
      check("ar_ctrl",  128'(out_ctrl),  128'(0));
      check("ar_occ",   128'(occupancy), 128'(0));
      check("ar_ready", 128'(in_ready),  128'(1));
      check("ar_data",  128'(out_data),  128'(0));
      #1 reset = 1'b0;
      @(negedge clock);
      drive(1'b1, 9'h088, 96'h88, 15'h0088);
      step();
      check("ar_next_data", 128'(out_data),  128'(96'h88));
      check("ar_next_occ",  128'(occupancy), 128'(1));
      drive(1'b0, '0, '0, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
